// File: rtl/fetch_pkg.sv
// Shared types and encodings for the dual-issue fetch queue.
package fetch_pkg;

   localparam int XLEN_DEF = 32;

   // One buffered fetch result.
   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] instr;
   } fetch_entry_t;

   // in_valid patterns; slot0 is always the older slot.
   localparam logic [1:0] IN_NONE    = 2'b00;
   localparam logic [1:0] IN_ONE     = 2'b01;
   localparam logic [1:0] IN_ILLEGAL = 2'b10;
   localparam logic [1:0] IN_TWO     = 2'b11;

   // deq_num values; 3 saturates to 2.
   localparam logic [1:0] DEQ_NONE = 2'd0;
   localparam logic [1:0] DEQ_ONE  = 2'd1;
   localparam logic [1:0] DEQ_TWO  = 2'd2;
   localparam logic [1:0] DEQ_SAT  = 2'd3;

   // Number of entries offered by an in_valid pattern (10 offers none).
   function automatic logic [1:0] enq_req_of(input logic [1:0] v);
      case (v)
         IN_ONE:              return 2'd1;
         IN_TWO:              return 2'd2;
         IN_NONE, IN_ILLEGAL: return 2'd0;
         default:             return 2'd0;
      endcase
   endfunction

   // Number of entries requested by decode, before clamping to occupancy.
   function automatic logic [1:0] deq_req_of(input logic [1:0] d);
      case (d)
         DEQ_ONE:          return 2'd1;
         DEQ_TWO, DEQ_SAT: return 2'd2;
         DEQ_NONE:         return 2'd0;
         default:          return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: DEPTH words, two write ports (tail, tail+1) and two
// combinational read ports (head, head+1). Write addresses never collide.
module fetch_queue_mem #(
   parameter int DEPTH = 8,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [$clog2(DEPTH)-1:0] waddr0,
   input  logic [$clog2(DEPTH)-1:0] waddr1,
   input  logic [W-1:0]             wdata0,
   input  logic [W-1:0]             wdata1,
   input  logic [$clog2(DEPTH)-1:0] raddr0,
   input  logic [$clog2(DEPTH)-1:0] raddr1,
   output logic [W-1:0]             rdata0,
   output logic [W-1:0]             rdata1
);

   logic [W-1:0] mem_q [DEPTH];

   // Write up to two entries per cycle; contents need no reset because
   // the control logic masks every slot that is not valid.
   always_ff @(posedge clk) begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
   end

   assign rdata0 = mem_q[raddr0];
   assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch buffer between fetch and 2-wide decode.
// Handshake: fetch may write when in_ready=1 (a registered function of
// occupancy only); the number of entries taken is given by in_valid and
// anything offered while in_ready=0 is dropped. Decode sees out_valid
// (00/01/11) and reports via deq_num how many head entries it consumed in
// the same cycle; requests beyond the occupancy are clamped.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int XLEN  = XLEN_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [1:0]             in_valid,
   input  logic [XLEN-1:0]        in_pc0,
   input  logic [XLEN-1:0]        in_instr0,
   input  logic [XLEN-1:0]        in_pc1,
   input  logic [XLEN-1:0]        in_instr1,
   output logic                   in_ready,
   output logic [1:0]             out_valid,
   output logic [XLEN-1:0]        out_pc0,
   output logic [XLEN-1:0]        out_instr0,
   output logic [XLEN-1:0]        out_pc1,
   output logic [XLEN-1:0]        out_instr1,
   input  logic [1:0]             deq_num,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]     head_q, head_d;
   logic [AW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [1:0]        enq_n, deq_eff, avail;
   logic              we0, we1;
   logic [AW-1:0]     tail_p1, head_p1;
   logic [2*XLEN-1:0] rdata0, rdata1;

   // Accept only when two free slots exist, so a 2-wide write always fits.
   assign in_ready = (count_q <= CW'(DEPTH - 2));
   assign enq_n    = in_ready ? enq_req_of(in_valid) : 2'd0;
   assign avail    = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
   assign tail_p1  = tail_q + AW'(1);
   assign head_p1  = head_q + AW'(1);
   assign we0      = !flush && (enq_n != 2'd0);
   assign we1      = !flush && (enq_n == 2'd2);

   // Clamp the decode request to what is actually buffered.
   always_comb begin
      deq_eff = deq_req_of(deq_num);
      if (deq_eff > avail) deq_eff = avail;
   end

   // Next pointers and occupancy; flush wins over enqueue and dequeue.
   always_comb begin
      head_d  = head_q + AW'(deq_eff);
      tail_d  = tail_q + AW'(enq_n);
      count_d = count_q + CW'(enq_n) - CW'(deq_eff);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Pointer and occupancy registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .W     (2 * XLEN)
   ) u_mem (
      .clk    (clk),
      .we0    (we0),
      .we1    (we1),
      .waddr0 (tail_q),
      .waddr1 (tail_p1),
      .wdata0 ({in_pc0, in_instr0}),
      .wdata1 ({in_pc1, in_instr1}),
      .raddr0 (head_q),
      .raddr1 (head_p1),
      .rdata0 (rdata0),
      .rdata1 (rdata1)
   );

   // Present the two oldest entries, zeroing any slot that is not valid.
   always_comb begin
      out_valid  = {count_q >= CW'(2), count_q >= CW'(1)};
      out_pc0    = '0;
      out_instr0 = '0;
      out_pc1    = '0;
      out_instr1 = '0;
      if (out_valid[0]) {out_pc0, out_instr0} = rdata0;
      if (out_valid[1]) {out_pc1, out_instr1} = rdata1;
   end

   assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-of-entries reference model predicts the
// post-edge outputs, a monitor compares them one edge later.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int EW    = 1 + 4 + 2 + 4 * XLEN;

  logic            clk, reset, flush;
  logic [1:0]      in_valid, deq_num, out_valid;
  logic [XLEN-1:0] in_pc0, in_instr0, in_pc1, in_instr1;
  logic [XLEN-1:0] out_pc0, out_instr0, out_pc1, out_instr1;
  logic            in_ready;
  logic [3:0]      count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc0     (in_pc0),
    .in_instr0  (in_instr0),
    .in_pc1     (in_pc1),
    .in_instr1  (in_instr1),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pc0    (out_pc0),
    .out_instr0 (out_instr0),
    .out_pc1    (out_pc1),
    .out_instr1 (out_instr1),
    .deq_num    (deq_num),
    .count      (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ---------------- reference model and scoreboard ----------------
  fetch_entry_t   model_q[$];
  logic [EW-1:0]  exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_model();
    int s;
    logic [1:0] v;
    fetch_entry_t e0, e1;
    s  = model_q.size();
    v  = (s >= 2) ? 2'b11 : (s >= 1) ? 2'b01 : 2'b00;
    e0 = '0;
    e1 = '0;
    if (s >= 1) e0 = model_q[0];
    if (s >= 2) e1 = model_q[1];
    return {(s <= DEPTH - 2), 4'(s), v, e0.pc, e0.instr, e1.pc, e1.instr};
  endfunction

  function automatic logic [EW-1:0] pack_dut();
    return {in_ready, count, out_valid, out_pc0, out_instr0, out_pc1, out_instr1};
  endfunction

  task automatic compare_all(input string tag, input logic [EW-1:0] exp);
    logic [EW-1:0] act;
    act = pack_dut();
    cmp({tag, ".in_ready"},   64'(act[EW-1]),       64'(exp[EW-1]));
    cmp({tag, ".count"},      64'(act[EW-2:EW-5]),  64'(exp[EW-2:EW-5]));
    cmp({tag, ".out_valid"},  64'(act[EW-6:EW-7]),  64'(exp[EW-6:EW-7]));
    cmp({tag, ".out_pc0"},    64'(act[127:96]),     64'(exp[127:96]));
    cmp({tag, ".out_instr0"}, 64'(act[95:64]),      64'(exp[95:64]));
    cmp({tag, ".out_pc1"},    64'(act[63:32]),      64'(exp[63:32]));
    cmp({tag, ".out_instr1"}, 64'(act[31:0]),       64'(exp[31:0]));
  endtask

  // Monitor: one expected snapshot per edge, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare_all("edge", exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] v, input logic [31:0] pc0,
                      input logic [1:0] dq, input logic fl);
    fetch_entry_t e0, e1;
    int n;
    bit ready;
    @(negedge clk);
    e0.pc = pc0;        e0.instr = $urandom;
    e1.pc = pc0 + 32'd4; e1.instr = $urandom;
    in_valid  = v;
    in_pc0    = e0.pc;  in_instr0 = e0.instr;
    in_pc1    = e1.pc;  in_instr1 = e1.instr;
    deq_num   = dq;
    flush     = fl;
    // Reference: decide acceptance on the pre-edge occupancy, then retire
    // the oldest entries, then append the accepted ones.
    ready = (model_q.size() <= DEPTH - 2);
    if (fl) begin
      model_q.delete();
    end else begin
      n = (dq == 2'd3) ? 2 : int'(dq);
      if (n > model_q.size()) n = model_q.size();
      repeat (n) void'(model_q.pop_front());
      if (ready && v == 2'b01) model_q.push_back(e0);
      if (ready && v == 2'b11) begin
        model_q.push_back(e0);
        model_q.push_back(e1);
      end
    end
    exp_q.push_back(pack_model());
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    in_valid = 2'b11;
    deq_num  = 2'd1;
    #2 reset = 1'b1;
    #1;
    model_q.delete();
    compare_all("async_rst", pack_model());
    #1 reset = 1'b0;
    in_valid = 2'b00;
    deq_num  = 2'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc;
    reset = 1'b1; flush = 1'b0; in_valid = 2'b00; deq_num = 2'd0;
    in_pc0 = '0; in_instr0 = '0; in_pc1 = '0; in_instr1 = '0;
    repeat (2) @(negedge clk);
    compare_all("reset", pack_model());
    reset = 1'b0;

    // idle, then one 2-wide enqueue
    step(2'b00, 32'h0, 2'd0, 1'b0);
    step(2'b11, 32'h0, 2'd0, 1'b0);

    // fill to DEPTH from empty, then an ignored fifth enqueue
    step(2'b00, 32'h0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b11, 32'(i * 8), 2'd0, 1'b0);
    step(2'b11, 32'h20, 2'd0, 1'b0);
    step(2'b00, 32'h0, 2'd0, 1'b0);

    // drain to 4 then steady enqueue 2 / dequeue 2 across the wrap
    step(2'b00, 32'h0, 2'd2, 1'b0);
    step(2'b00, 32'h0, 2'd2, 1'b0);
    pc = 32'h20;
    for (int i = 0; i < 10; i++) begin
      step(2'b11, pc, 2'd2, 1'b0);
      pc += 32'd8;
    end

    // count=1 with deq_num=2, then dequeue while empty
    step(2'b00, 32'h0, 2'd0, 1'b1);
    step(2'b01, 32'h80, 2'd0, 1'b0);
    step(2'b00, 32'h0, 2'd2, 1'b0);
    step(2'b00, 32'h0, 2'd1, 1'b0);

    // illegal pattern 10, then single entry
    step(2'b10, 32'h60, 2'd0, 1'b0);
    step(2'b01, 32'h40, 2'd0, 1'b0);

    // count=5 then flush with simultaneous enqueue and dequeue
    step(2'b11, 32'h44, 2'd0, 1'b0);
    step(2'b11, 32'h4c, 2'd0, 1'b0);
    step(2'b11, 32'h200, 2'd2, 1'b1);
    step(2'b01, 32'h100, 2'd0, 1'b0);

    // asynchronous reset mid-burst, then refill
    step(2'b11, 32'h300, 2'd0, 1'b0);
    step(2'b11, 32'h308, 2'd1, 1'b0);
    async_reset_pulse();
    step(2'b01, 32'h100, 2'd0, 1'b0);

    // randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), pc, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0));
      pc += 32'd8;
    end
    step(2'b00, 32'h0, 2'd0, 1'b0);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) cmp("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
